// File: rtl/sccb_arbiter.sv
// Two-port round-robin arbiter sharing one SCCB master between the config
// sequencer (port 0) and a runtime register writer (port 1), with a per-phase watchdog.
module sccb_arbiter #(
    parameter int CLK_FREQ   = 25000000,
    parameter int TIMEOUT_MS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_start,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_start,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       SCCB_interface_ready,
    output logic [7:0] SCCB_interface_addr,
    output logic [7:0] SCCB_interface_data,
    output logic       SCCB_interface_start,
    output logic       grant,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] error_count
);

    localparam logic [31:0] TIMEOUT_CYCLES = 32'((CLK_FREQ / 1000) * TIMEOUT_MS);
    localparam logic [31:0] WD_LOAD        = TIMEOUT_CYCLES - 32'd1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t      state;
    logic [1:0]  pending;
    logic [7:0]  buf_addr0;
    logic [7:0]  buf_data0;
    logic [7:0]  buf_addr1;
    logic [7:0]  buf_data1;
    logic        last_grant;
    logic [31:0] watchdog;
    logic        next_port;

    assign req0_ready = !pending[0];
    assign req1_ready = !pending[1];
    assign busy       = (state != IDLE);

    // On a tie the port that did not win last time goes next.
    always_comb begin
        next_port = pending[1];
        if (pending == 2'b11) begin
            next_port = !last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            pending              <= 2'b00;
            buf_addr0            <= 8'h00;
            buf_data0            <= 8'h00;
            buf_addr1            <= 8'h00;
            buf_data1            <= 8'h00;
            last_grant           <= 1'b1;
            grant                <= 1'b0;
            watchdog             <= 32'd0;
            SCCB_interface_addr  <= 8'h00;
            SCCB_interface_data  <= 8'h00;
            SCCB_interface_start <= 1'b0;
            timeout_err          <= 1'b0;
            error_count          <= 8'h00;
        end else begin
            SCCB_interface_start <= 1'b0;
            timeout_err          <= 1'b0;

            if (req0_start && !pending[0]) begin
                pending[0] <= 1'b1;
                buf_addr0  <= req0_addr;
                buf_data0  <= req0_data;
            end
            if (req1_start && !pending[1]) begin
                pending[1] <= 1'b1;
                buf_addr1  <= req1_addr;
                buf_data1  <= req1_data;
            end

            case (state)
                IDLE: begin
                    if (SCCB_interface_ready && (pending != 2'b00)) begin
                        SCCB_interface_addr  <= next_port ? buf_addr1 : buf_addr0;
                        SCCB_interface_data  <= next_port ? buf_data1 : buf_data0;
                        SCCB_interface_start <= 1'b1;
                        grant                <= next_port;
                        last_grant           <= next_port;
                        watchdog             <= WD_LOAD;
                        state                <= WAIT_ACK;
                    end
                end
                // Exit condition takes priority over an expiring watchdog.
                WAIT_ACK: begin
                    if (!SCCB_interface_ready) begin
                        watchdog <= WD_LOAD;
                        state    <= WAIT_DONE;
                    end else if (watchdog == 32'd0) begin
                        pending[grant] <= 1'b0;
                        timeout_err    <= 1'b1;
                        if (error_count != 8'hFF) begin
                            error_count <= error_count + 8'd1;
                        end
                        state <= IDLE;
                    end else begin
                        watchdog <= watchdog - 32'd1;
                    end
                end
                WAIT_DONE: begin
                    if (SCCB_interface_ready) begin
                        pending[grant] <= 1'b0;
                        state          <= IDLE;
                    end else if (watchdog == 32'd0) begin
                        pending[grant] <= 1'b0;
                        timeout_err    <= 1'b1;
                        if (error_count != 8'hFF) begin
                            error_count <= error_count + 8'd1;
                        end
                        state <= IDLE;
                    end else begin
                        watchdog <= watchdog - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Self-checking bench for sccb_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_sccb_arbiter;

    localparam int CLK_FREQ   = 1000;
    localparam int TIMEOUT_MS = 5;
    localparam int T          = (CLK_FREQ / 1000) * TIMEOUT_MS;

    logic       clk;
    logic       rst_n;
    logic       req0_start;
    logic [7:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_start;
    logic [7:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       sccb_ready;
    logic [7:0] sccb_addr;
    logic [7:0] sccb_data;
    logic       sccb_start;
    logic       grant;
    logic       busy;
    logic       timeout_err;
    logic [7:0] error_count;

    int checks   = 0;
    int failures = 0;

    sccb_arbiter #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req0_start           (req0_start),
        .req0_addr            (req0_addr),
        .req0_data            (req0_data),
        .req0_ready           (req0_ready),
        .req1_start           (req1_start),
        .req1_addr            (req1_addr),
        .req1_data            (req1_data),
        .req1_ready           (req1_ready),
        .SCCB_interface_ready (sccb_ready),
        .SCCB_interface_addr  (sccb_addr),
        .SCCB_interface_data  (sccb_data),
        .SCCB_interface_start (sccb_start),
        .grant                (grant),
        .busy                 (busy),
        .timeout_err          (timeout_err),
        .error_count          (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s0;
        logic [7:0] a0;
        logic [7:0] d0;
        logic       s1;
        logic [7:0] a1;
        logic [7:0] d1;
        logic       rdy;
        logic       r0;
        logic       r1;
        logic       st;
        logic [7:0] ea;
        logic [7:0] ed;
        logic       gr;
        logic       bs;
    } vec_t;

    vec_t vecs[12];

    // Reference model: per-port one-entry buffers, round-robin choice and a
    // cycle count per handshake phase compared against the timeout budget.
    bit [1:0]   mpend;
    logic [7:0] mbufa[2];
    logic [7:0] mbufd[2];
    bit         mlast;
    bit         mgrant;
    logic [7:0] maddr;
    logic [7:0] mdata;
    int         merr;
    bit         mbusy;
    int         mphase;
    int         mcnt;
    bit         mexpStart;
    bit         mexpTo;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s0, input logic [7:0] a0, input logic [7:0] d0,
                                 input logic s1, input logic [7:0] a1, input logic [7:0] d1,
                                 input logic rdy);
        req0_start = s0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_start = s1;
        req1_addr  = a1;
        req1_data  = d1;
        sccb_ready = rdy;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic modelReset();
        mpend     = 2'b00;
        mbufa[0]  = 8'h00;
        mbufa[1]  = 8'h00;
        mbufd[0]  = 8'h00;
        mbufd[1]  = 8'h00;
        mlast     = 1'b1;
        mgrant    = 1'b0;
        maddr     = 8'h00;
        mdata     = 8'h00;
        merr      = 0;
        mbusy     = 1'b0;
        mphase    = 0;
        mcnt      = 0;
        mexpStart = 1'b0;
        mexpTo    = 1'b0;
    endtask

    task automatic modelStep(input logic s0, input logic [7:0] a0, input logic [7:0] d0,
                             input logic s1, input logic [7:0] a1, input logic [7:0] d1,
                             input logic rdy);
        bit [1:0] old;
        bit       w;
        bit       leave;
        old       = mpend;
        mexpStart = 1'b0;
        mexpTo    = 1'b0;
        if (s0 && !old[0]) begin
            mpend[0] = 1'b1;
            mbufa[0] = a0;
            mbufd[0] = d0;
        end
        if (s1 && !old[1]) begin
            mpend[1] = 1'b1;
            mbufa[1] = a1;
            mbufd[1] = d1;
        end
        if (!mbusy) begin
            if (rdy && (old != 2'b00)) begin
                w         = (old == 2'b11) ? !mlast : old[1];
                mlast     = w;
                mgrant    = w;
                maddr     = mbufa[w];
                mdata     = mbufd[w];
                mexpStart = 1'b1;
                mbusy     = 1'b1;
                mphase    = 1;
                mcnt      = 0;
            end
        end else begin
            mcnt++;
            leave = (mphase == 1) ? !rdy : rdy;
            if (leave) begin
                if (mphase == 1) begin
                    mphase = 2;
                    mcnt   = 0;
                end else begin
                    mpend[mgrant] = 1'b0;
                    mbusy         = 1'b0;
                end
            end else if (mcnt == T) begin
                mpend[mgrant] = 1'b0;
                mbusy         = 1'b0;
                mexpTo        = 1'b1;
                if (merr < 255) merr++;
            end
        end
    endtask

    task automatic modelCompare(input string tag);
        checkOutput({tag, ".ready0"}, 32'(req0_ready), 32'(!mpend[0]));
        checkOutput({tag, ".ready1"}, 32'(req1_ready), 32'(!mpend[1]));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(mbusy));
        checkOutput({tag, ".start"}, 32'(sccb_start), 32'(mexpStart));
        checkOutput({tag, ".timeout_err"}, 32'(timeout_err), 32'(mexpTo));
        checkOutput({tag, ".error_count"}, 32'(error_count), 32'(merr));
        checkOutput({tag, ".grant"}, 32'(grant), 32'(mgrant));
        checkOutput({tag, ".addr"}, 32'(sccb_addr), 32'(maddr));
        checkOutput({tag, ".data"}, 32'(sccb_data), 32'(mdata));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".ready0"}, 32'(req0_ready), 32'd1);
        checkOutput({tag, ".ready1"}, 32'(req1_ready), 32'd1);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".start"}, 32'(sccb_start), 32'd0);
        checkOutput({tag, ".addr"}, 32'(sccb_addr), 32'd0);
        checkOutput({tag, ".data"}, 32'(sccb_data), 32'd0);
        checkOutput({tag, ".grant"}, 32'(grant), 32'd0);
        checkOutput({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
        checkOutput({tag, ".error_count"}, 32'(error_count), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int  scState;
        int  scCnt;
        bit  scHangDone;
        bit  seen;
        logic rdyDrv;
        logic s0, s1;
        logic [7:0] a0, d0, a1, d1;

        vecs[0]  = '{1'b1, 8'h11, 8'h01, 1'b1, 8'h3A, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 8'h01, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 8'hAA, 8'hBB, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h01, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h01, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h01, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h55, 8'h66, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3A, 8'h04, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3A, 8'h04, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h77, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3A, 8'h04, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 8'h66, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 8'h66, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'h66, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'h66, 1'b0, 1'b0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        doReset();
        checkResetValues("reset");

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].s0, vecs[i].a0, vecs[i].d0,
                          vecs[i].s1, vecs[i].a1, vecs[i].d1, vecs[i].rdy);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
            checkOutput($sformatf("vec%0d.ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
            checkOutput($sformatf("vec%0d.start", i), 32'(sccb_start), 32'(vecs[i].st));
            checkOutput($sformatf("vec%0d.addr", i), 32'(sccb_addr), 32'(vecs[i].ea));
            checkOutput($sformatf("vec%0d.data", i), 32'(sccb_data), 32'(vecs[i].ed));
            checkOutput($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].gr));
            checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].bs));
        end

        // Watchdog abort while the SCCB master never acknowledges.
        doReset();
        applyStimulus(1'b1, 8'h21, 8'h43, 1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("wd.start", 32'(sccb_start), 32'd1);
        checkOutput("wd.addr", 32'(sccb_addr), 32'h21);
        for (int k = 1; k <= T; k++) begin
            @(negedge clk);
            checkOutput($sformatf("wd.timeout_err_c%0d", k), 32'(timeout_err), 32'(k == T));
            checkOutput($sformatf("wd.busy_c%0d", k), 32'(busy), 32'(k < T));
            checkOutput($sformatf("wd.ready0_c%0d", k), 32'(req0_ready), 32'(k == T));
            checkOutput($sformatf("wd.start_c%0d", k), 32'(sccb_start), 32'd0);
        end
        @(negedge clk);
        checkOutput("wd.pulse_end", 32'(timeout_err), 32'd0);
        checkOutput("wd.error_count", 32'(error_count), 32'd1);

        // Round-robin alternation over four simultaneous pairs.
        doReset();
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            checkOutput($sformatf("alt%0d.ready0", p), 32'(req0_ready), 32'd1);
            checkOutput($sformatf("alt%0d.ready1", p), 32'(req1_ready), 32'd1);
            applyStimulus(1'b1, 8'(8'h10 + p), 8'h01, 1'b1, 8'(8'h20 + p), 8'h02, 1'b1);
            @(negedge clk);
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
            for (int j = 0; j < 2; j++) begin
                seen = 1'b0;
                for (int c = 0; c < 20 && !seen; c++) begin
                    @(negedge clk);
                    seen = sccb_start;
                end
                checkOutput($sformatf("alt%0d.start_seen%0d", p, j), 32'(seen), 32'd1);
                if (seen) begin
                    checkOutput($sformatf("alt%0d.grant%0d", p, j), 32'(grant), 32'(j));
                    checkOutput($sformatf("alt%0d.addr%0d", p, j), 32'(sccb_addr),
                                32'((j == 0) ? (8'h10 + p) : (8'h20 + p)));
                end
                sccb_ready = 1'b0;
                repeat (2) @(negedge clk);
                sccb_ready = 1'b1;
            end
        end

        // Error counter saturation with the SCCB master never acknowledging.
        doReset();
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < 20 && !req0_ready; c++) @(negedge clk);
            applyStimulus(1'b1, 8'h30, 8'h31, 1'b0, 8'h00, 8'h00, 1'b1);
            @(negedge clk);
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
            seen = 1'b0;
            for (int c = 0; c < 3 * T && !seen; c++) begin
                @(negedge clk);
                seen = timeout_err;
            end
            if (!seen) begin
                checkOutput($sformatf("sat.abort%0d", n), 32'd0, 32'd1);
                break;
            end
        end
        checkOutput("sat.error_count", 32'(error_count), 32'd255);

        // Reset asserted during WAIT_DONE, then normal operation afterwards.
        doReset();
        applyStimulus(1'b1, 8'h5A, 8'hC3, 1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("rst.start", 32'(sccb_start), 32'd1);
        sccb_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst.busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("rst.async");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h66, 8'h99, 1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("rst.after_start", 32'(sccb_start), 32'd1);
        checkOutput("rst.after_addr", 32'(sccb_addr), 32'h66);
        checkOutput("rst.after_data", 32'(sccb_data), 32'h99);
        checkOutput("rst.after_grant", 32'(grant), 32'd0);

        // Randomized traffic against the reference model, with a responsive
        // SCCB master that occasionally hangs in either handshake phase.
        doReset();
        modelReset();
        scState    = 0;
        scCnt      = 0;
        scHangDone = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            modelCompare("rand");
            if (sccb_start) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 8) begin
                    scState = 0;
                end else begin
                    scState    = 1;
                    scCnt      = int'($urandom_range(0, 2));
                    scHangDone = (r < 14);
                end
            end
            case (scState)
                1: begin
                    if (scCnt == 0) begin
                        rdyDrv  = 1'b0;
                        scState = 2;
                        scCnt   = scHangDone ? (T + 3) : int'($urandom_range(1, 3));
                    end else begin
                        scCnt--;
                        rdyDrv = 1'b1;
                    end
                end
                2: begin
                    scCnt--;
                    if (scCnt == 0) begin
                        rdyDrv  = 1'b1;
                        scState = 0;
                    end else begin
                        rdyDrv = 1'b0;
                    end
                end
                default: rdyDrv = ($urandom_range(0, 9) != 0);
            endcase
            s0 = ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 3) == 0);
            a0 = 8'($urandom);
            d0 = 8'($urandom);
            a1 = 8'($urandom);
            d1 = 8'($urandom);
            applyStimulus(s0, a0, d0, s1, a1, d1, rdyDrv);
            modelStep(s0, a0, d0, s1, a1, d1, rdyDrv);
            @(negedge clk);
        end
        modelCompare("rand.final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccb_arbiter.md
# sccb_arbiter

Two-port arbiter that shares the single SCCB interface between the ROM-driven camera configuration sequencer (port 0) and a runtime register writer (port 1, e.g. exposure/brightness tweaks). Each requester sees its own addr/data/start/ready handshake. The arbiter latches one pending write per port and grants ports round-robin. It issues one-cycle starts to the SCCB interface and tracks each transaction through acceptance and completion. A watchdog aborts transactions on which the SCCB interface hangs.

## Interface
- CLK_FREQ, 25000000, clock frequency in Hz
- TIMEOUT_MS, 10, per-phase watchdog in ms; TIMEOUT_CYCLES = (CLK_FREQ/1000)*TIMEOUT_MS
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_start  in  1  port 0 write request pulse (config sequencer)
- req0_addr  in  8  port 0 register address
- req0_data  in  8  port 0 register data
- req0_ready  out  1  port 0 can accept a request
- req1_start, req1_addr, req1_data, req1_ready  same as port 0, for port 1 (runtime writer)
- SCCB_interface_ready  in  1  SCCB master idle
- SCCB_interface_addr  out  8  register address to SCCB master
- SCCB_interface_data  out  8  register data to SCCB master
- SCCB_interface_start  out  1  one-cycle start to SCCB master
- grant  out  1  port owning the current or last transaction
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort
- error_count  out  8  number of aborts, saturates at 255

## Operation
- Per-port capture: reqN_start sampled while reqN_ready=1 latches addr/data into the port buffer and sets pendingN. reqN_start while reqN_ready=0 is ignored; no queueing beyond one entry.
- reqN_ready = !pendingN (combinational from the register).
- States:
  - IDLE:
    - If SCCB_interface_ready=1 and any pending, select a port.
    - Only one pending: that port wins. Both pending: the port != last_grant wins.
    - Drive SCCB_interface_addr/data from the selected buffer, SCCB_interface_start<=1, grant<=port, last_grant<=port, load watchdog, go to WAIT_ACK.
    - If SCCB_interface_ready=0, stay in IDLE.
  - WAIT_ACK: SCCB_interface_start<=0. On SCCB_interface_ready=0, reload watchdog and go to WAIT_DONE.
  - WAIT_DONE: on SCCB_interface_ready=1, clear pending[grant] and go to IDLE.
- Watchdog, active in WAIT_ACK and WAIT_DONE:
  - Counts down from TIMEOUT_CYCLES-1 (32-bit).
  - At 0 with the exit condition still unmet: clear pending[grant], pulse timeout_err, increment error_count (saturating), go to IDLE.
- SCCB_interface_addr/data hold their last value outside an issue.
- A start arriving in the same cycle its port's pending clears is ignored, because ready is still 0 that cycle.

## Timing
- Reset values:
  - State IDLE.
  - pending0/1=0, so req0_ready=req1_ready=1.
  - last_grant=1, so port 0 wins the first tie.
  - grant=0, busy=0, SCCB_interface_start=0, SCCB_interface_addr=0, SCCB_interface_data=0, timeout_err=0, error_count=0.
- Reset asserted mid-transaction returns everything to reset values immediately. Any in-flight SCCB transfer is abandoned.
- Request accepted at edge t: pendingN=1 and reqN_ready=0 from t+1. SCCB_interface_start is high for exactly the cycle after t+1, i.e. t+2, provided SCCB_interface_ready=1 at t+1.
- SCCB_interface_ready observed high in WAIT_DONE at edge u: pending cleared, reqN_ready=1 and IDLE at u+1. The earliest next start is at u+2.
- SCCB_interface_start never exceeds one cycle. There is never a second start before completion or abort of the previous transaction.
- Watchdog expiry: abort takes effect exactly TIMEOUT_CYCLES cycles after entering the phase. timeout_err is high for 1 cycle.

## Test plan
- Single port 0 write 0x12/0x80 with an SCCB model (ready low 100 cycles after start) -> one start pulse with addr=0x12, data=0x80. req0_ready low from accept until 1 cycle after ready returns. grant=0.
- Both ports request in the same cycle (p0 0x11/0x01, p1 0x3A/0x04) -> p0 issued first, p1 issued second. A following simultaneous pair is issued p1 first? No: last_grant=1, so p0 first; alternation is verified over 4 back-to-back pairs (0,1,0,1,...).
- req0_start pulsed again while pending0=1 with different data -> ignored; only the first addr/data reaches SCCB.
- SCCB model never drops ready after start, with CLK_FREQ=1000, TIMEOUT_MS=5 -> abort after 5 cycles in WAIT_ACK, timeout_err 1-cycle pulse, error_count=1, port ready again.
- SCCB ready stuck low at 300 consecutive aborts -> error_count saturates at 255.
- rst_n pulled low during WAIT_DONE -> outputs at reset values immediately, both ready=1. After release, a new request is issued normally.
